// File: rtl/unidad_muldiv.sv
// unidad_muldiv: iterative RV32M multiply/divide unit, one operation in flight.
// Shift-add multiply and restoring divide share one accumulator pair (acc_hi:acc_lo).
module unidad_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    localparam int CW = $clog2(ITER);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3;
    logic [4:0]      rd_q;
    logic            neg;
    logic [XLEN-1:0] ma, mb, acc_hi, acc_lo;

    logic              sgn_a, sgn_b, div0, ovf, lt;
    logic [XLEN-1:0]   mag_a, mag_b, sub, quo, rem, fin_val;
    logic [XLEN:0]     add_sum, shl;
    logic [2*XLEN-1:0] prod;

    assign sgn_a   = op_a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]));
    assign sgn_b   = op_b[XLEN-1] & ((funct3 == 3'b001) | (funct3[2] & ~funct3[0]));
    assign mag_a   = sgn_a ? -op_a : op_a;
    assign mag_b   = sgn_b ? -op_b : op_b;
    assign div0    = funct3[2] & (op_b == '0);
    assign ovf     = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    assign add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, ma} : '0);
    assign shl     = {acc_hi, acc_lo[XLEN-1]};
    assign lt      = shl < {1'b0, mb};
    assign sub     = shl[XLEN-1:0] - mb;
    assign prod    = neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo     = neg ? -acc_lo : acc_lo;
    assign rem     = neg ? -acc_hi : acc_hi;
    assign fin_val = f3[2] ? (f3[1] ? rem : quo) : (f3 == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    // Special cases preload the answer into acc_lo (quotient) and acc_hi (remainder) with neg=0.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
            cnt    <= '0;
            f3     <= '0;
            rd_q   <= '0;
            neg    <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else begin
            case (state)
                IDLE: if (start && !flush) begin
                    f3     <= funct3;
                    rd_q   <= rd_in;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    neg    <= (div0 | ovf) ? 1'b0 : (funct3[2] & funct3[1]) ? sgn_a : sgn_a ^ sgn_b;
                    ma     <= mag_a;
                    mb     <= mag_b;
                    acc_hi <= div0 ? op_a : '0;
                    acc_lo <= div0 ? '1 : ovf ? op_a : funct3[2] ? mag_a : mag_b;
                    state  <= (div0 | ovf) ? FIN : CALC;
                end
                CALC: if (flush) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    cnt    <= cnt + 1'b1;
                    acc_hi <= f3[2] ? (lt ? shl[XLEN-1:0] : sub) : add_sum[XLEN:1];
                    acc_lo <= f3[2] ? {acc_lo[XLEN-2:0], ~lt} : {add_sum[0], acc_lo[XLEN-1:1]};
                    if (cnt == CW'(ITER-1)) state <= FIN;
                end
                FIN: if (flush || done) begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    result <= fin_val;
                    rd_out <= rd_q;
                    done   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unidad_muldiv.sv
// tb_unidad_muldiv: scoreboard bench for the RV32M multiply/divide unit.
module tb_unidad_muldiv;
    logic        CLK = 1'b0, RST_n = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {logic [31:0] res; logic [4:0] rd; int lat;} exp_t;
    exp_t        sb[$];
    int          checks = 0, errors = 0, cyc = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    unidad_muldiv dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        logic        ov;
        xa = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        xb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = xa * xb;
        ov = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'b000:  return p[31:0];
            3'b100:  return (b == 0) ? 32'hFFFFFFFF : ov ? a : 32'($signed(a) / $signed(b));
            3'b101:  return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110:  return (b == 0) ? a : ov ? 32'h0 : 32'($signed(a) % $signed(b));
            3'b111:  return (b == 0) ? a : a % b;
            default: return p[63:32];
        endcase
    endfunction

    function automatic int latm(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
    endfunction

    // Caller is at a negedge; the request is accepted at the next posedge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat, input bit noise);
        exp_t e;
        int   k, n;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        sb.push_back('{exp, rd, lat});
        @(negedge CLK);
        start = 1'b0; op_a = ~a; op_b = $urandom; rd_in = ~rd; funct3 = ~f;
        k = cyc;
        chk("busy_on", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 60) begin
            if (noise && n == 5) begin start = 1'b1; op_a = $urandom; op_b = $urandom; end
            if (noise && n == 6) start = 1'b0;
            @(negedge CLK);
            n++;
        end
        e = sb.pop_front();
        if (!done) chk("timeout", 32'(done), 32'd1);
        else begin
            chk("result", result, e.res);
            chk("rd_out", 32'(rd_out), 32'(e.rd));
            chk("latency", 32'(cyc - k), 32'(e.lat));
            chk("busy_done", 32'(busy), 32'd1);
            last_res = e.res;
            last_rd  = e.rd;
            @(negedge CLK);
            chk("done_pulse", 32'(done), 32'd0);
            chk("busy_off", 32'(busy), 32'd0);
            chk("result_hold", result, last_res);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        #1 RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        RST_n = 1'b1;
        @(negedge CLK);
        issue(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33, 0);
        issue(3'b001, 32'h80000000, 32'hFFFFFFFF, 5'd1, 32'h00000000, 33, 0);
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h80000000, 33, 0);
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h7FFFFFFF, 33, 0);
        issue(3'b000, 32'h80000000, 32'hFFFFFFFF, 5'd4, 32'h80000000, 33, 0);
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 33, 0);
        issue(3'b110, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 33, 0);
        issue(3'b101, 32'd100, 32'd7, 5'd8, 32'd14, 33, 0);
        issue(3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 33, 0);
        issue(3'b100, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 1, 0);
        issue(3'b111, 32'd5, 32'd0, 5'd11, 32'd5, 1, 0);
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1, 0);
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0, 1, 0);
        issue(3'b000, 32'd0, 32'd9, 5'd0, 32'd0, 33, 0);
        issue(3'b000, 32'd12345, 32'd678, 5'd14, model(3'b000, 32'd12345, 32'd678), 33, 1);
        issue(3'b110, 32'hFFFF0001, 32'd37, 5'd15, model(3'b110, 32'hFFFF0001, 32'd37), 33, 1);
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (i == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            issue(f, a, b, 5'($urandom), model(f, a, b), latm(f, a, b), 0);
        end
        // Flush mid-CALC: no done, old result held, next start accepted immediately.
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd20;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result", result, last_res);
        chk("flush_rd", 32'(rd_out), 32'(last_rd));
        issue(3'b011, 32'hDEADBEEF, 32'h12345678, 5'd21, model(3'b011, 32'hDEADBEEF, 32'h12345678), 33, 0);
        // Flush and start together in IDLE: flush wins.
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd22;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        chk("fs_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        chk("fs_done", 32'(done), 32'd0);
        chk("fs_result", result, last_res);
        // Asynchronous reset mid-CALC.
        start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd23;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_rd", 32'(rd_out), 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        issue(3'b000, 32'd3, 32'd4, 5'd24, 32'd12, 33, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
